// File: rtl/aes_encrypt_core_param_if.sv
// Block-in / ciphertext-out handshake bundle for aes_encrypt_core_param.
// Byte 0 of DATA, CIPHER_KEY and ENCRYPTED_DATA sits in the most significant bits.
interface aes_encrypt_core_param_if #(
    parameter int KEY_BITS = 192
);
    logic                IN_VALID;
    logic                IN_READY;
    logic [127:0]        DATA;
    logic [KEY_BITS-1:0] CIPHER_KEY;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [127:0]        ENCRYPTED_DATA;
    logic                BUSY;

    modport master (
        output IN_VALID, DATA, CIPHER_KEY, OUT_READY,
        input  IN_READY, OUT_VALID, ENCRYPTED_DATA, BUSY
    );

    modport slave (
        input  IN_VALID, DATA, CIPHER_KEY, OUT_READY,
        output IN_READY, OUT_VALID, ENCRYPTED_DATA, BUSY
    );
endinterface

// File: rtl/aes_encrypt_core_param.sv
// Iterative AES-128/192/256 encryptor: sequential key expansion, then one round per clock.
// Optional AES_KEY_CACHE_EN skips key expansion when the key matches the last expanded one.
module aes_encrypt_core_param #(
    parameter int KEY_BITS = 192
) (
    input  logic                      CLK,
    input  logic                      RST,
    aes_encrypt_core_param_if.slave   aes_io
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);
    localparam logic [3:0] NR_R   = 4'(NR);
    localparam logic [5:0] LAST_W = 6'(NW - 1);

    if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
        $error("aes_encrypt_core_param: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1, S_ROUND = 2'd2, S_DONE = 2'd3} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    // Byte n = 4*column + row; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_e       state_q;
    logic [127:0] data_q;
    logic [127:0] enc_q;
    logic [31:0]  w_q [60];
    logic [5:0]   i_q;
    logic [2:0]   kmod_q;
    logic [7:0]   rcon_q;
    logic [3:0]   r_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         hit_s;
    logic [31:0]  temp_s;
    logic [127:0] rkey_s;
    logic [127:0] sr_s;
    logic [127:0] round_s;

`ifdef AES_KEY_CACHE_EN
    logic [KEY_BITS-1:0] ckey_q;
    logic                cvalid_q;
    assign hit_s = cvalid_q && (aes_io.CIPHER_KEY == ckey_q);
`else
    assign hit_s = 1'b0;
`endif

    // Next key word transform; kmod_q tracks i mod NK and rcon_q tracks Rcon[i/NK].
    always_comb begin
        temp_s = w_q[i_q - 6'd1];
        if (kmod_q == 3'd0) begin
            temp_s = sub_word({temp_s[23:0], temp_s[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            temp_s = sub_word(temp_s);
        end else begin
            temp_s = w_q[i_q - 6'd1];
        end
    end

    // Round datapath; round 0 is key whitening only, the last round drops MixColumns.
    always_comb begin
        rkey_s = {w_q[{r_q, 2'b00}], w_q[{r_q, 2'b01}], w_q[{r_q, 2'b10}], w_q[{r_q, 2'b11}]};
        sr_s   = shift_rows(sub_bytes(data_q));
        if (r_q == 4'd0) begin
            round_s = data_q ^ rkey_s;
        end else if (r_q == NR_R) begin
            round_s = sr_s ^ rkey_s;
        end else begin
            round_s = mix_columns(sr_s) ^ rkey_s;
        end
    end

    // Control FSM with registered handshake outputs, key schedule and cipher state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            data_q      <= 128'h0;
            enc_q       <= 128'h0;
            i_q         <= 6'd0;
            kmod_q      <= 3'd0;
            rcon_q      <= 8'h00;
            r_q         <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            ckey_q      <= '0;
            cvalid_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (aes_io.IN_VALID && in_ready_q) begin
                        data_q <= aes_io.DATA;
                        for (int j = 0; j < NK; j++)
                            w_q[6'(j)] <= aes_io.CIPHER_KEY[KEY_BITS-1-32*j -: 32];
                        i_q        <= NK_W;
                        kmod_q     <= 3'd0;
                        rcon_q     <= 8'h01;
                        r_q        <= 4'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= hit_s ? S_ROUND : S_EXPAND;
`ifdef AES_KEY_CACHE_EN
                        if (!hit_s) begin
                            ckey_q   <= aes_io.CIPHER_KEY;
                            cvalid_q <= 1'b0;
                        end
`endif
                    end
                end
                S_EXPAND: begin
                    w_q[i_q] <= w_q[i_q - NK_W] ^ temp_s;
                    i_q      <= i_q + 6'd1;
                    kmod_q   <= (kmod_q == NK_M1) ? 3'd0 : kmod_q + 3'd1;
                    if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
                    if (i_q == LAST_W) begin
                        r_q     <= 4'd0;
                        state_q <= S_ROUND;
`ifdef AES_KEY_CACHE_EN
                        cvalid_q <= 1'b1;
`endif
                    end
                end
                S_ROUND: begin
                    data_q <= round_s;
                    if (r_q == NR_R) begin
                        enc_q       <= round_s;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        r_q <= r_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (aes_io.OUT_READY) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign aes_io.IN_READY       = in_ready_q;
    assign aes_io.OUT_VALID      = out_valid_q;
    assign aes_io.ENCRYPTED_DATA = enc_q;
    assign aes_io.BUSY           = busy_q;
endmodule

// File: tb/tb_aes_encrypt_core_param.sv
// Directed bench for aes_encrypt_core_param: FIPS-197 / SP800-38A vectors on 128/192/256-bit cores,
// backpressure, mid-round reset and (with AES_KEY_CACHE_EN) key-cache latency.
module tb_aes_encrypt_core_param;
`ifdef AES_KEY_CACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 51;
`endif
    localparam logic [255:0] KEY0_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY1_128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY0_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY0_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;

    logic         clk = 1'b0;
    logic         rst_v = 1'b1;
    logic [2:0]   in_valid_v = 3'b000;
    logic [2:0]   out_ready_v = 3'b000;
    logic [127:0] data_v = 128'h0;
    logic [255:0] key_v = 256'h0;
    int           sel_v = 0;
    int           checks = 0;
    int           errors = 0;

    aes_encrypt_core_param_if #(.KEY_BITS(128)) if128 ();
    aes_encrypt_core_param_if #(.KEY_BITS(192)) if192 ();
    aes_encrypt_core_param_if #(.KEY_BITS(256)) if256 ();

    aes_encrypt_core_param #(.KEY_BITS(128)) dut128 (.CLK(clk), .RST(rst_v), .aes_io(if128.slave));
    aes_encrypt_core_param #(.KEY_BITS(192)) dut192 (.CLK(clk), .RST(rst_v), .aes_io(if192.slave));
    aes_encrypt_core_param #(.KEY_BITS(256)) dut256 (.CLK(clk), .RST(rst_v), .aes_io(if256.slave));

    assign if128.IN_VALID = in_valid_v[0];
    assign if192.IN_VALID = in_valid_v[1];
    assign if256.IN_VALID = in_valid_v[2];
    assign if128.OUT_READY = out_ready_v[0];
    assign if192.OUT_READY = out_ready_v[1];
    assign if256.OUT_READY = out_ready_v[2];
    assign if128.DATA = data_v;
    assign if192.DATA = data_v;
    assign if256.DATA = data_v;
    assign if128.CIPHER_KEY = key_v[255:128];
    assign if192.CIPHER_KEY = key_v[255:64];
    assign if256.CIPHER_KEY = key_v;

    logic         ov_s, ir_s, busy_s;
    logic [127:0] enc_s;
    assign ov_s   = (sel_v == 0) ? if128.OUT_VALID : (sel_v == 1) ? if192.OUT_VALID : if256.OUT_VALID;
    assign ir_s   = (sel_v == 0) ? if128.IN_READY  : (sel_v == 1) ? if192.IN_READY  : if256.IN_READY;
    assign busy_s = (sel_v == 0) ? if128.BUSY      : (sel_v == 1) ? if192.BUSY      : if256.BUSY;
    assign enc_s  = (sel_v == 0) ? if128.ENCRYPTED_DATA :
                    (sel_v == 1) ? if192.ENCRYPTED_DATA : if256.ENCRYPTED_DATA;

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if (ov_s !== 1'b0 || ir_s !== 1'b1 || busy_s !== 1'b0 || enc_s !== 128'h0) begin
            errors++;
            $display("FAIL %s: ov=%b ir=%b busy=%b enc=%h, required ov=0 ir=1 busy=0 enc=0",
                     name, ov_s, ir_s, busy_s, enc_s);
        end
    endtask

    // Drives one block into core sel and waits for OUT_VALID; abort_at >= 0 pulses RST at that cycle.
    task automatic run_block(input int sel, input logic [255:0] key, input logic [127:0] pt,
                             input logic [127:0] exp_ct, input int exp_lat, input int abort_at,
                             input string name);
        int lat;
        bit busy_ok;
        @(negedge clk);
        sel_v = sel;
        key_v = key;
        data_v = pt;
        in_valid_v[sel] = 1'b1;
        #1;
        checks++;
        if (ir_s !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b required 1", name, ir_s);
        end
        @(posedge clk);
        #1;
        in_valid_v = 3'b000;
        key_v = ~key;
        data_v = ~pt;
        lat = 0;
        busy_ok = 1'b1;
        while (ov_s !== 1'b1 && lat < 200) begin
            if (busy_s !== 1'b1 || ir_s !== 1'b0) busy_ok = 1'b0;
            if (lat == abort_at) begin
                @(negedge clk);
                rst_v = 1'b1;
                @(posedge clk);
                #1;
                rst_v = 1'b0;
                check_reset_outputs({name, "_abort"});
                return;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (enc_s !== exp_ct) begin
            errors++;
            $display("FAIL %s_ciphertext: got %h required %h", name, enc_s, exp_ct);
        end
        checks++;
        if (!busy_ok || busy_s !== 1'b0 || ir_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_window: busy_ok=%b busy=%b ir=%b, required 1 0 0",
                     name, busy_ok, busy_s, ir_s);
        end
    endtask

    task automatic release_out(input int sel, input logic [127:0] exp_ct, input string name);
        @(negedge clk);
        sel_v = sel;
        out_ready_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[sel] = 1'b0;
        checks++;
        if (ov_s !== 1'b0 || ir_s !== 1'b1 || enc_s !== exp_ct) begin
            errors++;
            $display("FAIL %s_release: ov=%b ir=%b enc=%h, required ov=0 ir=1 enc=%h",
                     name, ov_s, ir_s, enc_s, exp_ct);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_v = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel_v = s;
            #1;
            check_reset_outputs($sformatf("reset_core%0d", s));
        end
    endtask

    task automatic test_fips128();
        run_block(0, KEY0_128, PT0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 51, -1, "fips128");
        release_out(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips128");
    endtask

    task automatic test_key_cache();
        run_block(0, KEY0_128, PT0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, HIT_LAT, -1, "same_key");
        release_out(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "same_key");
        run_block(0, KEY1_128, PT1, 128'h3925841d02dc09fbdc118597196a0b32, 51, -1, "new_key");
        release_out(0, 128'h3925841d02dc09fbdc118597196a0b32, "new_key");
    endtask

    task automatic test_backpressure();
        bit held_ok;
        run_block(0, KEY1_128, PT2, 128'h3ad77bb40d7a3660a89ecaf32466ef97, HIT_LAT, -1, "bp");
        held_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid_v[0] = (c % 3 == 0);
            data_v = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            if (ov_s !== 1'b1 || ir_s !== 1'b0 || enc_s !== 128'h3ad77bb40d7a3660a89ecaf32466ef97)
                held_ok = 1'b0;
        end
        in_valid_v = 3'b000;
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL bp_hold: output not held (last ov=%b ir=%b enc=%h), required ov=1 ir=0 enc=3ad77bb4...",
                     ov_s, ir_s, enc_s);
        end
        release_out(0, 128'h3ad77bb40d7a3660a89ecaf32466ef97, "bp");
        run_block(0, KEY0_128, PT0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 51, -1, "b2b");
        release_out(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "b2b");
    endtask

    task automatic test_reset_midround();
        run_block(0, KEY1_128, PT1, 128'h3925841d02dc09fbdc118597196a0b32, 51, 45, "midround");
        run_block(0, KEY1_128, PT1, 128'h3925841d02dc09fbdc118597196a0b32, 51, -1, "after_reset");
        release_out(0, 128'h3925841d02dc09fbdc118597196a0b32, "after_reset");
    endtask

    task automatic test_fips192();
        run_block(1, KEY0_192, PT0, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 59, -1, "fips192");
        release_out(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "fips192");
    endtask

    task automatic test_fips256();
        run_block(2, KEY0_256, PT0, 128'h8ea2b7ca516745bfeafc49904b496089, 67, -1, "fips256");
        release_out(2, 128'h8ea2b7ca516745bfeafc49904b496089, "fips256");
    endtask

    initial begin
        test_reset();
        test_fips128();
        test_key_cache();
        test_backpressure();
        test_reset_midround();
        test_fips192();
        test_fips256();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
